// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, codes and constant helpers for the result display
package display_pkg;

    // One 4-bit code per display digit: 0-9 are decimal digits, CODE_DASH draws a dash.
    typedef logic [3:0] digit_t;

    localparam digit_t CODE_DASH = 4'hA;
    localparam digit_t CODE_ZERO = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    // 10^n as a 64-bit constant, used for the overflow limits.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Number of decimal digits needed for the largest WIDTH-bit value.
    function automatic int dec_digits(input int width);
        logic [63:0] m;
        int          n;
        m = (64'd1 << width) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (m >= 64'd10) begin
                m = m / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary to BCD converter
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : accepted only in IDLE; captures bin
//   bin        : WIDTH-bit unsigned input
//   busy       : high from the accepting edge until the edge leaving COMMIT
//   done       : high for the single COMMIT cycle; bcd is final while done=1
//   bcd        : NIBBLES packed BCD digits, least significant nibble at [3:0]
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NIBBLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    conv_state_t           state;
    logic [CW-1:0]         cnt;
    logic [WIDTH-1:0]      bin_r;
    logic [4*NIBBLES-1:0]  bcd_r;
    logic [4*NIBBLES-1:0]  bcd_adj;

    // Add-3 correction applied before every shift so that a nibble >= 5
    // carries correctly into the next decade once doubled.
    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < NIBBLES; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            bin_r <= '0;
            bcd_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_r <= bin;
                        bcd_r <= '0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd_r, bin_r} <= {bcd_adj, bin_r} << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        done  <= 1'b1;
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - BCD conversion, sign/overflow commit and digit multiplexing
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   value_in   : unsigned magnitude, neg_in : sign flag
//   load       : one-cycle convert request, ignored while busy
//   busy       : conversion in progress
//   overflow   : last committed value did not fit the display
//   digit_num  : code of the currently selected digit (0-9, 4'hA dash)
//   digit_sel  : one-hot enable of the currently selected digit (bit 0 = LSD)
module display_scan_controller
    import display_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value_in,
    input  logic              neg_in,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [3:0]        digit_num,
    output logic [DIGITS-1:0] digit_sel
);

    localparam int BCD_N = (dec_digits(WIDTH) > DIGITS) ? dec_digits(WIDTH) : DIGITS;
    localparam logic [63:0] LIMIT_POS = pow10(DIGITS);
    localparam logic [63:0] LIMIT_NEG = pow10(DIGITS - 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    typedef digit_t digit_arr_t [DIGITS];

    digit_arr_t          held;
    digit_arr_t          held_d;
    logic                start;
    logic                conv_busy;
    logic                conv_done;
    logic [4*BCD_N-1:0]  conv_bcd;
    logic                neg_r;
    logic                ovf_pend;
    logic [63:0]         value_ext;
    logic [RW-1:0]       rcnt;
    logic [RW-1:0]       rcnt_d;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_d;
    logic                rwrap;

    assign start     = load & ~conv_busy;
    assign busy      = conv_busy;
    assign value_ext = 64'(value_in);

    bin_to_bcd_seq #(
        .WIDTH   (WIDTH),
        .NIBBLES (BCD_N)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (value_in),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Sign and overflow are decided when the request is accepted, so the
    // converter only has to deal with the magnitude.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_r    <= 1'b0;
            ovf_pend <= 1'b0;
        end else if (start) begin
            neg_r    <= neg_in;
            ovf_pend <= neg_in ? (value_ext >= LIMIT_NEG) : (value_ext >= LIMIT_POS);
        end
    end

    // Next held digits: only the COMMIT cycle changes them.
    always_comb begin
        held_d = held;
        if (conv_done) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (ovf_pend) begin
                    held_d[i] = CODE_DASH;
                end else if (neg_r && (i == DIGITS - 1)) begin
                    held_d[i] = CODE_DASH;
                end else begin
                    held_d[i] = conv_bcd[4*i +: 4];
                end
            end
        end
    end

    always_comb begin
        rwrap  = (rcnt == RW'(REFRESH_DIV - 1));
        rcnt_d = rwrap ? '0 : rcnt + 1'b1;
        idx_d  = idx;
        if (rwrap) begin
            idx_d = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // digit_num is taken from the next-state digits and index so that it
    // always matches digit_sel and a fresh commit shows up on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held      <= '{default: CODE_ZERO};
            overflow  <= 1'b0;
            rcnt      <= '0;
            idx       <= '0;
            digit_sel <= DIGITS'(1);
            digit_num <= CODE_ZERO;
        end else begin
            held      <= held_d;
            if (conv_done) begin
                overflow <= ovf_pend;
            end
            rcnt      <= rcnt_d;
            idx       <= idx_d;
            digit_sel <= DIGITS'(1) << idx_d;
            digit_num <= held_d[idx_d];
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
module tb_display_scan_controller;

    localparam int W   = 8;
    localparam int D   = 3;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] value_in = '0;
    logic         neg_in = 1'b0;
    logic         load = 1'b0;
    logic         busy;
    logic         overflow;
    logic [3:0]   digit_num;
    logic [D-1:0] digit_sel;

    always #5 clk = ~clk;

    display_scan_controller #(
        .WIDTH       (W),
        .DIGITS      (D),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_in  (value_in),
        .neg_in    (neg_in),
        .load      (load),
        .busy      (busy),
        .overflow  (overflow),
        .digit_num (digit_num),
        .digit_sel (digit_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: what the display must show, from cycle counts and decimal arithmetic.
    bit m_valid = 1'b0;
    int m_busy_left;
    int m_held [D];
    bit m_ovf;
    int m_t;
    int m_val;
    bit m_neg;

    function automatic int pw10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_commit();
        bit o;
        o = m_neg ? (m_val >= pw10(D - 1)) : (m_val >= pw10(D));
        m_ovf = o;
        for (int i = 0; i < D; i++) begin
            if (o) m_held[i] = 10;
            else if (m_neg && i == D - 1) m_held[i] = 10;
            else m_held[i] = (m_val / pw10(i)) % 10;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_valid     = 1'b1;
            m_busy_left = 0;
            for (int i = 0; i < D; i++) m_held[i] = 0;
            m_ovf = 1'b0;
            m_t   = 0;
        end else if (m_valid) begin
            m_t++;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) model_commit();
            end else if (load) begin
                m_busy_left = W + 1;
                m_val = int'(value_in);
                m_neg = neg_in;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    int c_idx;
    always @(negedge clk) begin
        if (m_valid) begin
            c_idx = (m_t / DIV) % D;
            chk("busy", 32'(busy), 32'(m_busy_left > 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("digit_sel", 32'(digit_sel), 32'(1 << c_idx));
            chk("digit_num", 32'(digit_num), 32'(m_held[c_idx]));
        end
    end

    task automatic do_load(input int v, input bit n);
        load = 1'b1;
        value_in = W'(v);
        neg_in = n;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic expect_digits(input string name, input int d0, input int d1, input int d2, input bit ovf);
        logic [3:0] seen [D];
        for (int i = 0; i < D; i++) seen[i] = 4'hF;
        for (int k = 0; k < D * DIV + 2; k++) begin
            for (int i = 0; i < D; i++) begin
                if (digit_sel === D'(1 << i)) seen[i] = digit_num;
            end
            tick();
        end
        chk({name, "_d0"}, 32'(seen[0]), 32'(d0));
        chk({name, "_d1"}, 32'(seen[1]), 32'(d1));
        chk({name, "_d2"}, 32'(seen[2]), 32'(d2));
        chk({name, "_ovf"}, 32'(overflow), 32'(ovf));
    endtask

    int blen;
    int special [8] = '{0, 9, 10, 99, 100, 101, 150, 255};

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_sel", 32'(digit_sel), 32'd1);
        chk("rst_num", 32'(digit_num), 32'd0);
        repeat (16) tick();

        // 123 positive: busy length and digits
        do_load(123, 1'b0);
        blen = 0;
        while (busy === 1'b1 && blen < 40) begin
            blen++;
            tick();
        end
        chk("busy_len", 32'(blen), 32'd9);
        expect_digits("v123", 3, 2, 1, 1'b0);

        do_load(45, 1'b1);
        wait_idle();
        expect_digits("n45", 5, 4, 10, 1'b0);

        do_load(150, 1'b1);
        wait_idle();
        expect_digits("n150", 10, 10, 10, 1'b1);

        do_load(255, 1'b0);
        wait_idle();
        expect_digits("v255", 5, 5, 2, 1'b0);

        // 99 with loads during SHIFT and in COMMIT; 255's digits stay until commit
        do_load(99, 1'b0);
        for (int e = 1; e <= 9; e++) begin
            if (e == 3 || e == 9) begin
                load = 1'b1;
                value_in = W'(7);
                neg_in = 1'b0;
            end
            if (e < 9 && digit_sel === D'(1)) chk("old_digit0", 32'(digit_num), 32'd5);
            tick();
            load = 1'b0;
        end
        chk("after_commit_busy", 32'(busy), 32'd0);
        expect_digits("v99", 9, 9, 0, 1'b0);

        do_load(0, 1'b0);
        wait_idle();
        expect_digits("v0", 0, 0, 0, 1'b0);

        do_load(123, 1'b0);
        wait_idle();

        // reset in the 4th SHIFT cycle of a conversion of 200
        do_load(200, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sel", 32'(digit_sel), 32'd1);
        chk("mid_rst_num", 32'(digit_num), 32'd0);
        do_load(8, 1'b0);
        wait_idle();
        expect_digits("v8", 8, 0, 0, 1'b0);

        // randomized traffic, checked every cycle by the model
        for (int k = 0; k < 2000; k++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            load   = ($urandom_range(0, 3) == 0);
            neg_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) value_in = W'(special[$urandom_range(0, 7)]);
            else value_in = W'($urandom);
            tick();
        end
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Front end of the calculator's result display; sits directly upstream of the 7-segment decoder.
- Takes a binary result plus a sign flag on a load pulse and converts it to BCD sequentially using shift-add-3 (double dabble).
- Holds the converted digits, then time-multiplexes them: one 4-bit digit code per refresh slot on `digit_num`, with a matching one-hot digit enable.

Parameters:
- WIDTH, 8: bit width of the unsigned magnitude `value_in`.
- DIGITS, 3: number of physical display digits. Must be ≥ 2.
- REFRESH_DIV, 50000: clock cycles each digit stays selected. Must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- value_in  in  WIDTH  unsigned magnitude to display.
- neg_in  in  1  sign flag; 1 means the value is negative.
- load  in  1  single-cycle request to convert `value_in`/`neg_in`.
- busy  out  1  conversion in progress.
- overflow  out  1  last committed value did not fit the display.
- digit_num  out  4  digit code for the decoder: 0-9 are digits, 4'hA is a dash.
- digit_sel  out  DIGITS  one-hot, active-high enable of the digit currently driven.

Behaviour:
- Reset (rst_n=0 at a rising edge) sets:
  - busy=0, overflow=0.
  - All held digits = 0.
  - Refresh counter = 0, scan index = 0.
  - digit_sel = 1 (digit 0, the least significant), digit_num = 0.
- Reset mid-conversion aborts the conversion. The held digits revert to 0, not to the previous value.

Converter FSM has states IDLE, SHIFT, COMMIT.
- IDLE:
  - If load=1, capture value_in and neg_in, clear the BCD accumulator, load the iteration counter with WIDTH, and go to SHIFT. busy=1 from this edge.
  - Overflow is decided at capture against a localparam limit:
    - neg_in=0: value ≥ 10^DIGITS.
    - neg_in=1: value ≥ 10^(DIGITS-1).
- SHIFT, one iteration per cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Then shift {bcd, bin} left by 1.
  - Decrement the counter. After the WIDTH-th iteration, go to COMMIT.
- COMMIT:
  - Write the held digits and the overflow flag, clear busy, return to IDLE.
  - Total: load seen at edge 0, new digits and busy=0 visible after edge WIDTH+1. busy is high for exactly WIDTH+1 cycles.
- Commit rules:
  - overflow=1: all digits = 4'hA.
  - neg=1, no overflow: the most significant digit = 4'hA, the rest are the low DIGITS-1 BCD nibbles.
  - Otherwise: the low DIGITS BCD nibbles.
  - No leading-zero blanking.
- Held digits change only at COMMIT, so the display never shows a partial conversion.
- load while busy=1 is ignored; there is no queueing.
- A load in the same cycle as COMMIT is also ignored, because the FSM is still in COMMIT. A new load is accepted from the next cycle.
- value_in = 0 displays all zeros. A negative zero displays "-0…0"; no special case.

Scan:
- The refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index increments, and wraps from DIGITS-1 to 0.
- digit_sel = 1 << index; digit_num = held_digit[index]. Both are registered and change on the same edge.
- The scan runs continuously, independent of busy.
- REFRESH_DIV=1 means the index advances every cycle.

Decomposition:
- Package display_pkg holds:
  - digit code typedef (logic [3:0]).
  - CODE_DASH = 4'hA.
  - Digit-array typedef parameterised by DIGITS, via a parameterised struct or unpacked array in the module.
- Sub-module bin_to_bcd_seq contains the FSM plus shift-add-3 datapath. Interface: start, bin, done, bcd.
- The top module holds the overflow/sign commit logic and the scan counter.

Test Plan (WIDTH=8, DIGITS=3, REFRESH_DIV=4):
- Reset, no load → busy=0, overflow=0, digit_sel cycles 001→010→100→001 every 4 cycles, digit_num=0 throughout.
- load value 123, neg 0 → busy high exactly 9 cycles; afterwards digit_num shows 3, 2, 1 when digit_sel = 001, 010, 100; overflow=0.
- load 45, neg 1 → digits (LSB first) 5, 4, A; overflow=0. Then load 150, neg 1 → all digits A, overflow=1.
- load 255, neg 0 → 5, 5, 2. Then load 0 → 0, 0, 0.
- During a conversion of 99: assert load with 7 at cycle 3, and again in the COMMIT cycle → both ignored; result is 9, 9, 0; old digits stay visible until commit.
- Start a conversion of 200, drop rst_n in the 4th SHIFT cycle → busy=0, all digits 0, digit_sel=001 on the next cycle; a following load of 8 → 8, 0, 0.
